mkio_rt_sequencer: RTL and testbench
====================================

// Module: mkio_rt_sequencer
// PURPOSE
//  MKIO (MIL-STD-1553) remote-terminal message sequencer; sole owner of the shared Manchester transmitter.
//  Decodes command words from the receiver, writes receive-subaddress data words to the RX buffer,
//  enforces response gap and word timeouts, emits the status word, and streams transmit-subaddress words from the TX buffer.
// PARAMETERS
//  ADDRESS      5'd1    terminal address matched against rx_data[15:11]
//  SUBADDR_RX   5'd3    receive subaddress (T/R=0, BC->RT)
//  SUBADDR_TX   5'd5    transmit subaddress (T/R=1, RT->BC)
//  GAP_CYC      16'd96  clk cycles from last received word to status-word tx_ready
//  WORD_TO_CYC  16'd400 max clk cycles between data words / tx_busy handshake edges
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  rx_done      in   1   one-cycle pulse: rx_data/rx_cd/p_error valid
//  rx_data      in   16  received word
//  rx_cd        in   1   0 = command/status sync, 1 = data sync
//  p_error      in   1   parity/Manchester error on current word
//  tx_ready     out  1   one-cycle pulse: start transmitting tx_data
//  tx_data      out  16  word to transmit, held until next tx_ready
//  tx_cd        out  1   0 = status sync, 1 = data sync
//  tx_busy      in   1   transmitter busy
//  wr_en        out  1   RX buffer write strobe (one cycle per data word)
//  wr_addr      out  5   RX buffer word index
//  wr_data      out  16  RX buffer write data
//  rd_req       out  1   TX buffer read strobe; rd_data valid next cycle
//  rd_addr      out  5   TX buffer word index
//  rd_data      in   16  TX buffer read data
//  svc_req, subsys_flag, dev_busy  in 1 each  status bits 8, 2, 3
//  busy_rx      out  1   high while RX buffer is being written (RX_DATA)
//  busy_tx      out  1   high while TX buffer is being read (TX_FETCH..TX_WAIT)
//  msg_done     out  1   one-cycle pulse: message completed with response
//  msg_err      out  1   one-cycle pulse: message aborted, no response
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sticky ME flag 0, counters 0.
//  Valid command = rx_done & ~rx_cd & ~p_error & rx_data[15:11]==ADDRESS; latch T/R=[10], SA=[9:5], WC=[4:0] (0 means 32).
//  IDLE: valid cmd with (T/R=0,SA_RX) -> RX_DATA; (T/R=1,SA_TX) -> GAP; any other SA/mode code (0,31) ignored.
//  RX_DATA: rx_done&rx_cd&~p_error -> wr_en same cycle, wr_addr=idx, idx++; idx==WC -> GAP.
//   dev_busy=1 at command accept: words consumed, wr_en suppressed, busy_rx=0.
//   p_error, or no word within WORD_TO_CYC -> set ME, msg_err, IDLE.
//   valid cmd mid-message: abort current (ME set, msg_err) and decode new cmd in same cycle.
//  GAP: count GAP_CYC cycles; rx_done with rx_cd=1 (excess word) -> ME, msg_err, IDLE; valid cmd -> supersede as above.
//  TX_STATUS: when ~tx_busy drive tx_data={ADDRESS,ME,1'b0,svc_req,3'b0,1'b0,dev_busy,subsys_flag,2'b0}, tx_cd=0, tx_ready pulse;
//   ME cleared in that cycle. T/R=0 or dev_busy latched -> TX_WAIT then IDLE + msg_done; else TX_FETCH.
//  TX_FETCH: rd_req pulse, rd_addr=idx; next cycle register rd_data -> TX_DATA.
//  TX_DATA: when ~tx_busy: tx_data=word, tx_cd=1, tx_ready pulse, idx++ -> TX_WAIT.
//  TX_WAIT: wait tx_busy rise then fall; then idx==WC -> IDLE + msg_done, else TX_FETCH.
//   Rise or fall missing within WORD_TO_CYC -> msg_err, IDLE.
//  Receiver input ignored from TX_STATUS through end of TX_WAIT.
//  Latency: status tx_ready exactly GAP_CYC+1 cycles after last rx_done when tx_busy=0.
//  idx 6-bit, compared to WC with 0 mapped to 32; wr_addr/rd_addr = idx[4:0].
//  Reset deassertion mid-message: FSM restarts in IDLE; no partial word issued.
// STRUCTURE
//  mkio_defs.vh: state encodings, status-word bit positions, CD sync constants.
//  Sub-module mkio_gap_timer: loadable 16-bit down-counter with expire pulse, shared by gap and word-timeout timing.
// TESTING
//  RX cmd 0x0863 (addr1,T/R0,SA3,WC3) + 3 data words -> wr_addr 0,1,2; status 0x0800 GAP_CYC+1 cycles later; msg_done.
//  TX cmd 0x0CA2 (SA5,WC2), rd_data 0xA5A5,0x5A5A -> status(tx_cd=0), then 2 data words tx_cd=1, msg_done.
//  RX WC=2, second word p_error -> msg_err, no tx_ready; next valid cmd status = 0x0C00 (ME), following = 0x0800.
//  WC field 0 -> exactly 32 words accepted/sent, idx wraps addr 31->done; extra data word in GAP -> msg_err.
//  Cmd to addr 2, SA7, or mode code SA0 -> no outputs change; dev_busy=1 -> status 0x0808 only, no wr_en/rd_req.
//  tx_busy held 1 after tx_ready beyond WORD_TO_CYC -> msg_err, IDLE; reset low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/mkio_rt_sequencer_pkg.sv
// Shared types and constants for the MKIO remote-terminal sequencer.
package mkio_rt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_GAP,
    ST_TX_STATUS,
    ST_TX_FETCH,
    ST_TX_DATA,
    ST_TX_WAIT
  } state_e;

  localparam int unsigned STS_ME_BIT     = 10;
  localparam int unsigned STS_SVC_BIT    = 8;
  localparam int unsigned STS_BUSY_BIT   = 3;
  localparam int unsigned STS_SUBSYS_BIT = 2;

  localparam logic CD_CMD  = 1'b0;
  localparam logic CD_DATA = 1'b1;

  // A word-count field of zero stands for 32 words.
  function automatic logic [5:0] wc_to_count(input logic [4:0] wc);
    return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
  endfunction

  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic me,
                                              input logic svc, input logic busy,
                                              input logic subsys);
    logic [15:0] w;
    w                 = '0;
    w[15:11]          = addr;
    w[STS_ME_BIT]     = me;
    w[STS_SVC_BIT]    = svc;
    w[STS_BUSY_BIT]   = busy;
    w[STS_SUBSYS_BIT] = subsys;
    return w;
  endfunction

endpackage

// File: rtl/mkio_rt_sequencer_gap_timer.sv
// Loadable 16-bit down-counter; expire_o is high for the single cycle the count sits at 1.
module mkio_gap_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        expire_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == 16'd1);

endmodule

// File: rtl/mkio_rt_sequencer.sv
// MIL-STD-1553 remote-terminal message sequencer: command decode, RX buffer writes,
// response gap / word timeouts, status word and TX-buffer word streaming.
module mkio_rt_sequencer
  import mkio_rt_sequencer_pkg::*;
#(
  parameter logic [4:0]  ADDRESS     = 5'd1,
  parameter logic [4:0]  SUBADDR_RX  = 5'd3,
  parameter logic [4:0]  SUBADDR_TX  = 5'd5,
  parameter logic [15:0] GAP_CYC     = 16'd96,
  parameter logic [15:0] WORD_TO_CYC = 16'd400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error,
  output logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  input  logic        tx_busy,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data,
  input  logic        svc_req,
  input  logic        subsys_flag,
  input  logic        dev_busy,
  output logic        busy_rx,
  output logic        busy_tx,
  output logic        msg_done,
  output logic        msg_err
);

  state_e      state_q, state_d;
  logic        me_q, me_d, tr_q, tr_d, dbusy_q, dbusy_d;
  logic        fetch_q, fetch_d, rise_q, rise_d, tx_cd_q, tx_cd_d;
  logic [4:0]  wc_q, wc_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d, tx_data_q, tx_data_d;
  logic        tmr_load, tmr_exp;
  logic [15:0] tmr_val;
  logic        cmd_valid, cmd_rx, cmd_tx, data_ok, accept, status_only;
  logic [5:0]  wc_cnt;

  mkio_gap_timer u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  assign cmd_valid   = rx_done & (rx_cd == CD_CMD) & ~p_error & (rx_data[15:11] == ADDRESS);
  assign cmd_rx      = cmd_valid & ~rx_data[10] & (rx_data[9:5] == SUBADDR_RX);
  assign cmd_tx      = cmd_valid &  rx_data[10] & (rx_data[9:5] == SUBADDR_TX);
  assign data_ok     = rx_done & (rx_cd == CD_DATA) & ~p_error;
  assign status_only = ~tr_q | dbusy_q;
  assign wc_cnt      = wc_to_count(wc_q);

  always_comb begin
    state_d   = state_q;
    me_d      = me_q;
    tr_d      = tr_q;
    dbusy_d   = dbusy_q;
    fetch_d   = fetch_q;
    rise_d    = rise_q;
    wc_d      = wc_q;
    idx_d     = idx_q;
    word_d    = word_q;
    tx_data_d = tx_data_q;
    tx_cd_d   = tx_cd_q;
    tmr_load  = 1'b0;
    tmr_val   = WORD_TO_CYC;
    tx_ready  = 1'b0;
    wr_en     = 1'b0;
    rd_req    = 1'b0;
    msg_done  = 1'b0;
    msg_err   = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      ST_IDLE: accept = 1'b1;
      ST_RX_DATA: begin
        if (cmd_valid) begin
          me_d = 1'b1; msg_err = 1'b1; state_d = ST_IDLE; accept = 1'b1;
        end else if (rx_done && p_error) begin
          me_d = 1'b1; msg_err = 1'b1; state_d = ST_IDLE;
        end else if (data_ok) begin
          wr_en    = ~dbusy_q;
          idx_d    = idx_q + 6'd1;
          tmr_load = 1'b1;
          if (idx_q + 6'd1 == wc_cnt) begin
            state_d = ST_GAP;
            tmr_val = GAP_CYC;
          end
        end else if (tmr_exp) begin
          me_d = 1'b1; msg_err = 1'b1; state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cmd_valid) begin
          me_d = 1'b1; msg_err = 1'b1; state_d = ST_IDLE; accept = 1'b1;
        end else if (rx_done && rx_cd == CD_DATA) begin
          me_d = 1'b1; msg_err = 1'b1; state_d = ST_IDLE;
        end else if (tmr_exp) begin
          state_d = ST_TX_STATUS;
        end
      end
      ST_TX_STATUS: begin
        if (!tx_busy) begin
          tx_ready  = 1'b1;
          tx_data_d = status_word(ADDRESS, me_q, svc_req, dev_busy, subsys_flag);
          tx_cd_d   = CD_CMD;
          me_d      = 1'b0;
          if (status_only) begin
            state_d = ST_TX_WAIT; rise_d = 1'b0; tmr_load = 1'b1;
          end else begin
            state_d = ST_TX_FETCH; fetch_d = 1'b0;
          end
        end
      end
      // Two cycles: strobe rd_req, then capture rd_data once the buffer has answered.
      ST_TX_FETCH: begin
        if (!fetch_q) begin
          rd_req  = 1'b1;
          fetch_d = 1'b1;
        end else begin
          word_d  = rd_data;
          state_d = ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        if (!tx_busy) begin
          tx_ready  = 1'b1;
          tx_data_d = word_q;
          tx_cd_d   = CD_DATA;
          idx_d     = idx_q + 6'd1;
          state_d   = ST_TX_WAIT;
          rise_d    = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      ST_TX_WAIT: begin
        if (tmr_exp) begin
          msg_err = 1'b1; state_d = ST_IDLE;
        end else if (!rise_q) begin
          if (tx_busy) begin
            rise_d = 1'b1; tmr_load = 1'b1;
          end
        end else if (!tx_busy) begin
          if (status_only || idx_q == wc_cnt) begin
            msg_done = 1'b1; state_d = ST_IDLE;
          end else begin
            state_d = ST_TX_FETCH; fetch_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A superseding command is decoded in the same cycle the old message is aborted.
    if (accept && (cmd_rx || cmd_tx)) begin
      tr_d     = rx_data[10];
      wc_d     = rx_data[4:0];
      dbusy_d  = dev_busy;
      idx_d    = '0;
      tmr_load = 1'b1;
      if (cmd_rx) begin
        state_d = ST_RX_DATA;
        tmr_val = WORD_TO_CYC;
      end else begin
        state_d = ST_GAP;
        tmr_val = GAP_CYC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      me_q      <= 1'b0;
      tr_q      <= 1'b0;
      dbusy_q   <= 1'b0;
      fetch_q   <= 1'b0;
      rise_q    <= 1'b0;
      wc_q      <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      tx_data_q <= '0;
      tx_cd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      me_q      <= me_d;
      tr_q      <= tr_d;
      dbusy_q   <= dbusy_d;
      fetch_q   <= fetch_d;
      rise_q    <= rise_d;
      wc_q      <= wc_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      tx_data_q <= tx_data_d;
      tx_cd_q   <= tx_cd_d;
    end
  end

  assign tx_data = tx_data_d;
  assign tx_cd   = tx_cd_d;
  assign wr_addr = wr_en  ? idx_q[4:0] : '0;
  assign wr_data = wr_en  ? rx_data    : '0;
  assign rd_addr = rd_req ? idx_q[4:0] : '0;
  assign busy_rx = (state_q == ST_RX_DATA) & ~dbusy_q;
  assign busy_tx = ((state_q == ST_TX_FETCH) | (state_q == ST_TX_DATA) |
                    (state_q == ST_TX_WAIT)) & ~status_only;

endmodule

// File: tb/tb_mkio_rt_sequencer.sv
// Directed bench for mkio_rt_sequencer with a simple transmitter and TX-buffer model.
module tb_mkio_rt_sequencer;

  logic        clk = 1'b0, reset = 1'b0;
  logic        rx_done = 1'b0, rx_cd = 1'b0, p_error = 1'b0, tx_busy = 1'b0;
  logic [15:0] rx_data = '0, rd_data = '0;
  logic        svc_req = 1'b0, subsys_flag = 1'b0, dev_busy = 1'b0;
  logic        tx_ready, tx_cd, wr_en, rd_req, busy_rx, busy_tx, msg_done, msg_err;
  logic [15:0] tx_data, wr_data;
  logic [4:0]  wr_addr, rd_addr, rd_a;

  logic [15:0] mem [32];
  int unsigned cyc = 0, rx_last = 0, tx_first = 0, cnt_txr = 0, cnt_done = 0, cnt_err = 0;
  int unsigned n_pass = 0, n_fail = 0, n_checks = 0;
  logic [15:0] txw [$];
  logic        txcd [$];
  logic [4:0]  wra [$];
  logic [15:0] wrd [$];
  logic [4:0]  rda [$];
  bit          saw_brx = 0, saw_btx = 0, tx_stuck = 0;

  mkio_rt_sequencer #(
    .ADDRESS(5'd1), .SUBADDR_RX(5'd3), .SUBADDR_TX(5'd5),
    .GAP_CYC(16'd96), .WORD_TO_CYC(16'd400)
  ) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_cd(rx_cd),
    .p_error(p_error), .tx_ready(tx_ready), .tx_data(tx_data), .tx_cd(tx_cd),
    .tx_busy(tx_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .svc_req(svc_req),
    .subsys_flag(subsys_flag), .dev_busy(dev_busy), .busy_rx(busy_rx),
    .busy_tx(busy_tx), .msg_done(msg_done), .msg_err(msg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rx_done) rx_last = cyc;
    if (tx_ready) begin
      txw.push_back(tx_data);
      txcd.push_back(tx_cd);
      if (cnt_txr == 0) tx_first = cyc;
      cnt_txr++;
    end
    if (wr_en) begin
      wra.push_back(wr_addr);
      wrd.push_back(wr_data);
    end
    if (rd_req) rda.push_back(rd_addr);
    if (msg_done) cnt_done++;
    if (msg_err)  cnt_err++;
    if (busy_rx)  saw_brx = 1;
    if (busy_tx)  saw_btx = 1;
  end

  // Transmitter: busy rises the cycle after tx_ready, holds 6 cycles (or while stuck).
  initial forever begin
    @(negedge clk);
    if (tx_ready) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (6) @(posedge clk);
      while (tx_stuck) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // TX buffer: registered read, data valid the cycle after rd_req.
  initial forever begin
    @(negedge clk);
    if (rd_req) begin
      rd_a = rd_addr;
      @(posedge clk); #1 rd_data = mem[rd_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    txw.delete(); txcd.delete(); wra.delete(); wrd.delete(); rda.delete();
    cnt_txr = 0; cnt_done = 0; cnt_err = 0; saw_brx = 0; saw_btx = 0;
  endtask

  task automatic send(input logic [15:0] w, input logic cd, input logic perr);
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = w; rx_cd = cd; p_error = perr;
    @(posedge clk); #1;
    rx_done = 1'b0; rx_cd = 1'b0; p_error = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_end(input string tag, input int unsigned maxc);
    int unsigned n = 0;
    while (cnt_done == 0 && cnt_err == 0 && n < maxc) begin
      @(posedge clk); n++;
    end
    chk(tag, 32'(cnt_done + cnt_err != 0), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_ctl", {tx_ready, tx_cd, wr_en, rd_req, busy_rx, busy_tx, msg_done, msg_err}, 0);
    chk("reset_data", {tx_data, wr_data}, 0);
    chk("reset_addr", {wr_addr, rd_addr}, 0);
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // RX message, WC=3
    clr();
    send(16'h0863, 1'b0, 1'b0);
    chk("rx_busy_rx", busy_rx, 1);
    send(16'h1111, 1'b1, 1'b0);
    send(16'h2222, 1'b1, 1'b0);
    send(16'h3333, 1'b1, 1'b0);
    wait_end("rx_end", 400);
    chk("rx_wr_cnt", wra.size(), 3);
    if (wra.size() == 3) begin
      chk("rx_wr_addr", {wra[0], wra[1], wra[2]}, {5'd0, 5'd1, 5'd2});
      chk("rx_wr_data0", wrd[0], 16'h1111);
      chk("rx_wr_data2", wrd[2], 16'h3333);
    end
    chk("rx_tx_cnt", cnt_txr, 1);
    if (cnt_txr == 1) begin
      chk("rx_status", txw[0], 16'h0800);
      chk("rx_status_cd", txcd[0], 0);
    end
    chk("rx_latency", tx_first - rx_last, 97);
    chk("rx_done_err", {cnt_done[7:0], cnt_err[7:0]}, 16'h0100);

    // TX message, WC=2
    clr();
    mem[0] = 16'hA5A5; mem[1] = 16'h5A5A;
    send(16'h0CA2, 1'b0, 1'b0);
    wait_end("tx_end", 600);
    chk("tx_word_cnt", cnt_txr, 3);
    if (cnt_txr == 3) begin
      chk("tx_status", txw[0], 16'h0800);
      chk("tx_words", {txw[1], txw[2]}, 32'hA5A55A5A);
      chk("tx_cds", {txcd[0], txcd[1], txcd[2]}, 3'b011);
    end
    chk("tx_rd_cnt", rda.size(), 2);
    chk("tx_latency", tx_first - rx_last, 97);
    chk("tx_done", cnt_done, 1);
    chk("tx_busy_tx", saw_btx, 1);

    // RX WC=2 with parity error on second word, then ME reported once
    clr();
    send(16'h0862, 1'b0, 1'b0);
    send(16'h4444, 1'b1, 1'b0);
    send(16'h5555, 1'b1, 1'b1);
    repeat (150) @(posedge clk);
    chk("perr_err", cnt_err, 1);
    chk("perr_no_tx", cnt_txr, 0);
    chk("perr_wr_cnt", wra.size(), 1);
    clr();
    send(16'h0861, 1'b0, 1'b0);
    send(16'h6666, 1'b1, 1'b0);
    wait_end("me_end", 400);
    chk("me_status", (cnt_txr == 1) ? txw[0] : 16'hxxxx, 16'h0C00);
    clr();
    send(16'h0861, 1'b0, 1'b0);
    send(16'h6767, 1'b1, 1'b0);
    wait_end("me_clr_end", 400);
    chk("me_clr_status", (cnt_txr == 1) ? txw[0] : 16'hxxxx, 16'h0800);

    // WC field 0: 32 words received
    clr();
    send(16'h0860, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) send(16'hB000 + 16'(i), 1'b1, 1'b0);
    wait_end("wc0_rx_end", 400);
    chk("wc0_rx_cnt", wra.size(), 32);
    if (wra.size() == 32) chk("wc0_rx_last", {wra[31], wrd[31]}, {5'd31, 16'hB01F});
    chk("wc0_rx_done", cnt_done, 1);

    // WC field 0: 32 words transmitted
    clr();
    for (int i = 0; i < 32; i++) mem[i] = 16'hC000 + 16'(i);
    send(16'h0CA0, 1'b0, 1'b0);
    wait_end("wc0_tx_end", 3000);
    chk("wc0_tx_cnt", cnt_txr, 33);
    if (cnt_txr == 33) chk("wc0_tx_last", txw[32], 16'hC01F);
    chk("wc0_rd_cnt", rda.size(), 32);
    if (rda.size() == 32) chk("wc0_rd_last", rda[31], 5'd31);

    // Excess data word during the response gap
    clr();
    send(16'h0861, 1'b0, 1'b0);
    send(16'h7070, 1'b1, 1'b0);
    send(16'h7171, 1'b1, 1'b0);
    repeat (150) @(posedge clk);
    chk("excess_err", cnt_err, 1);
    chk("excess_no_tx", cnt_txr, 0);
    clr();
    send(16'h0861, 1'b0, 1'b0);
    send(16'h7272, 1'b1, 1'b0);
    wait_end("excess_me_end", 400);
    chk("excess_me_status", (cnt_txr == 1) ? txw[0] : 16'hxxxx, 16'h0C00);

    // Commands not for this terminal / subaddress / mode code
    clr(); send(16'h1063, 1'b0, 1'b0); repeat (120) @(posedge clk);
    chk("ign_addr2", wra.size() + cnt_txr + rda.size() + cnt_done + cnt_err + saw_brx + saw_btx, 0);
    clr(); send(16'h08E3, 1'b0, 1'b0); repeat (120) @(posedge clk);
    chk("ign_sa7", wra.size() + cnt_txr + rda.size() + cnt_done + cnt_err + saw_brx + saw_btx, 0);
    clr(); send(16'h0803, 1'b0, 1'b0); repeat (120) @(posedge clk);
    chk("ign_sa0", wra.size() + cnt_txr + rda.size() + cnt_done + cnt_err + saw_brx + saw_btx, 0);

    // Device busy: RX words consumed silently, TX sends status only
    dev_busy = 1'b1;
    clr();
    send(16'h0862, 1'b0, 1'b0);
    send(16'h8181, 1'b1, 1'b0);
    send(16'h8282, 1'b1, 1'b0);
    wait_end("dbusy_rx_end", 400);
    chk("dbusy_rx_nowr", wra.size() + saw_brx, 0);
    chk("dbusy_rx_status", (cnt_txr == 1) ? txw[0] : 16'hxxxx, 16'h0808);
    clr();
    send(16'h0CA2, 1'b0, 1'b0);
    wait_end("dbusy_tx_end", 400);
    chk("dbusy_tx_only", {cnt_txr[7:0], rda.size() == 0, saw_btx}, {8'd1, 1'b1, 1'b0});
    chk("dbusy_tx_status", (cnt_txr == 1) ? txw[0] : 16'hxxxx, 16'h0808);
    chk("dbusy_tx_done", cnt_done, 1);
    dev_busy = 1'b0;

    // Transmitter stuck busy past the word timeout
    clr();
    tx_stuck = 1;
    send(16'h0861, 1'b0, 1'b0);
    send(16'h9090, 1'b1, 1'b0);
    wait_end("stuck_end", 1200);
    chk("stuck_err", {cnt_err[7:0], cnt_done[7:0]}, 16'h0100);
    tx_stuck = 0;
    repeat (20) @(posedge clk);

    // Reset asserted in the middle of a TX message
    clr();
    mem[0] = 16'hA5A5; mem[1] = 16'h5A5A;
    send(16'h0CA2, 1'b0, 1'b0);
    for (int n = 0; n < 300 && !busy_tx; n++) @(negedge clk);
    chk("rst_mid_reached", busy_tx, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ctl", {tx_ready, wr_en, rd_req, busy_rx, busy_tx, msg_done, msg_err}, 0);
    chk("rst_mid_data", {tx_data, tx_cd, rd_addr}, 0);
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    clr();
    repeat (60) @(posedge clk);
    chk("rst_mid_quiet", cnt_txr + cnt_done + cnt_err, 0);
    clr();
    send(16'h0861, 1'b0, 1'b0);
    send(16'hABCD, 1'b1, 1'b0);
    wait_end("post_rst_end", 400);
    chk("post_rst_status", (cnt_txr == 1) ? txw[0] : 16'hxxxx, 16'h0800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
